// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus bit-serial shifts, with flags.
// Latency: ops 000-101 finish in 1 cycle (back-to-back OK); shifts take min(b,BITS)+2 cycles.
// Backpressure: ready_out drops while a shift runs; start_in is ignored (not queued) until IDLE.
module ula_seq #(
    parameter int BITS = 8,
    parameter int OP   = 3
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            start_in,
    input  logic [OP-1:0]   op_in,
    input  logic [BITS-1:0] a_in,
    input  logic [BITS-1:0] b_in,
    input  logic            abort_in,
    output logic            ready_out,
    output logic            done_out,
    output logic [BITS-1:0] result_out,
    output logic            carry_out,
    output logic            zero_out,
    output logic            neg_out,
    output logic            ovf_out
);

    // Counter must be able to hold the value BITS itself (amounts are clamped to BITS).
    localparam int            CW       = $clog2(BITS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BITS);
    localparam logic [BITS:0] BITS_EXT = (BITS + 1)'(BITS);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]      state;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] sreg;
    logic            last_out;   // most recent bit shifted out; becomes the shift carry
    logic            dir_left;

    logic [2:0]      opc;
    logic [BITS:0]   sum;
    logic [BITS:0]   diff;
    logic [BITS-1:0] alu_res;
    logic            alu_c;
    logic            alu_v;
    logic [CW-1:0]   shift_amt;

    assign opc       = op_in[2:0];
    assign sum       = {1'b0, a_in} + {1'b0, b_in};
    // Bit BITS of the widened difference is the unsigned borrow (a < b).
    assign diff      = {1'b0, a_in} - {1'b0, b_in};
    assign shift_amt = ({1'b0, b_in} >= BITS_EXT) ? CNT_MAX : b_in[CW-1:0];
    assign ready_out = (state == IDLE);

    // Single-cycle datapath for the non-shift opcodes.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opc)
            3'b000: alu_res = ~b_in;
            3'b001: alu_res = a_in & b_in;
            3'b010: alu_res = a_in | b_in;
            3'b011: alu_res = a_in ^ b_in;
            3'b100: begin
                alu_res = sum[BITS-1:0];
                alu_c   = sum[BITS];
                alu_v   = (a_in[BITS-1] == b_in[BITS-1]) && (sum[BITS-1] != a_in[BITS-1]);
            end
            3'b101: begin
                alu_res = diff[BITS-1:0];
                alu_c   = diff[BITS];
                alu_v   = (a_in[BITS-1] != b_in[BITS-1]) && (diff[BITS-1] != a_in[BITS-1]);
            end
            default: ;
        endcase
    end

    // Control FSM, shifter and registered result/flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            last_out   <= 1'b0;
            dir_left   <= 1'b0;
            done_out   <= 1'b0;
            result_out <= '0;
            carry_out  <= 1'b0;
            zero_out   <= 1'b0;
            neg_out    <= 1'b0;
            ovf_out    <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    // An abort in IDLE suppresses a simultaneous start.
                    if (start_in && !abort_in) begin
                        if (opc[2:1] == 2'b11) begin
                            sreg     <= a_in;
                            cnt      <= shift_amt;
                            last_out <= 1'b0;
                            dir_left <= ~opc[0];
                            state    <= SHIFT;
                        end else begin
                            result_out <= alu_res;
                            carry_out  <= alu_c;
                            zero_out   <= (alu_res == '0);
                            neg_out    <= alu_res[BITS-1];
                            ovf_out    <= alu_v;
                            done_out   <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (abort_in) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        if (dir_left) begin
                            {last_out, sreg} <= {sreg, 1'b0};
                        end else begin
                            {sreg, last_out} <= {1'b0, sreg};
                        end
                        cnt <= cnt - 1'b1;
                    end else begin
                        result_out <= sreg;
                        carry_out  <= last_out;
                        zero_out   <= (sreg == '0);
                        neg_out    <= sreg[BITS-1];
                        ovf_out    <= 1'b0;
                        done_out   <= 1'b1;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter BITS, default 8, SHALL set operand/result width (BITS >= 2).
REQ-002 Parameter OP, default 3, SHALL set opcode width; only the 3 LSBs are decoded.
REQ-003 Port clk_in, input, 1, SHALL be the sole clock; all state updates on its rising edge.
REQ-004 Port rst_in, input, 1, SHALL be the asynchronous active-high reset.
REQ-005 Port start_in, input, 1, SHALL request an operation; accepted only when ready_out=1 at the rising edge.
REQ-006 Port op_in, input, OP, SHALL select the operation and is sampled on acceptance.
REQ-007 Ports a_in and b_in, input, BITS each, SHALL carry the operands and are sampled on acceptance.
REQ-008 Port abort_in, input, 1, SHALL cancel an in-progress shift.
REQ-009 Port ready_out, output, 1, SHALL be high exactly when the FSM is in IDLE.
REQ-010 Port done_out, output, 1, SHALL pulse high for one cycle when result_out/flags update.
REQ-011 Port result_out, output, BITS, SHALL hold the last completed result.
REQ-012 Ports carry_out, zero_out, neg_out, ovf_out, output, 1 each, SHALL hold the flags of the last completed result.

Function
REQ-013 Opcodes SHALL be: 000 ~b; 001 a&b; 010 a|b; 011 a^b; 100 a+b; 101 a-b; 110 a<<b; 111 a>>b (logical).
REQ-014 FSM SHALL have states IDLE and SHIFT; ops 000-101 never leave IDLE.
REQ-015 Ops 000-101 SHALL write result/flags on the accepting edge: done_out high the following cycle (latency 1), ready_out stays high, back-to-back acceptance every cycle allowed.
REQ-016 Ops 110/111 SHALL load a into a shift register, cnt = min(b, BITS) (b unsigned, full width), enter SHIFT.
REQ-017 In SHIFT, each edge with cnt != 0 SHALL shift by one bit, record the bit shifted out, and decrement cnt.
REQ-018 In SHIFT with cnt = 0 the edge SHALL write result/flags, pulse done_out, return to IDLE; shift latency = min(b,BITS) + 2 cycles.
REQ-019 start_in SHALL be ignored while in SHIFT; operands of an ignored request are discarded.
REQ-020 abort_in high in SHIFT SHALL return to IDLE at that edge without done_out; result/flags unchanged; abort_in in IDLE has no effect and takes priority over start_in there.
REQ-021 zero_out = (result == 0); neg_out = result[BITS-1].
REQ-022 carry_out SHALL be: add carry-out of bit BITS-1; sub borrow (1 when a < b unsigned); shift last bit shifted out (0 when amount 0); logic ops 0.
REQ-023 ovf_out SHALL be signed two's-complement overflow for add/sub, 0 otherwise.
REQ-024 Add/sub SHALL wrap modulo 2^BITS; shift amount >= BITS SHALL yield result 0.
REQ-025 Shift counter SHALL be sized for value BITS (clog2(BITS+1) bits).

Reset
REQ-026 rst_in high SHALL immediately force state IDLE, cnt 0, shift register 0, result_out 0, all flags 0, done_out 0.
REQ-027 ready_out SHALL read 1 during and after reset; start_in during reset SHALL be ignored.
REQ-028 Reset mid-shift SHALL discard the operation with no done_out after release.

Verification (BITS=8, OP=3)
REQ-029 add 0xFF+0x01 -> next cycle done_out=1, result 0x00, carry 1, zero 1, ovf 0, neg 0.
REQ-030 add 0x7F+0x01 -> result 0x80, ovf 1, neg 1, carry 0; then sub 0x03-0x05 on the next cycle -> result 0xFE, carry 1, neg 1, ovf 0 (back-to-back, ready_out never low).
REQ-031 shr 0x0E by 2 -> ready_out low 3 cycles, done_out 4 cycles after accept, result 0x03, carry 1.
REQ-032 shl 0x01 by 200 -> done_out 10 cycles after accept, result 0x00, zero 1, carry 1; start_in pulsed mid-shift ignored.
REQ-033 shl 0xFF by 5, abort_in at 2nd SHIFT cycle -> IDLE next cycle, no done_out, result/flags keep prior values.
REQ-034 shl 0xFF by 5, rst_in asserted mid-shift between clock edges -> outputs 0 immediately, ready_out 1, no done_out after release.
